// File: rtl/edac_access_ctrl_if.sv
// Bus bundle for edac_access_ctrl: CPU read port, memory read/write port and EDAC operand/result signals.
// master = the sequencer, slave = the CPU, memory and EDAC side.
interface edac_access_ctrl_if #(
    parameter int AW = 10
);
    logic          cpu_req;
    logic [AW-1:0] cpu_addr;
    logic          cpu_gnt;
    logic [15:0]   cpu_rdata;
    logic          cpu_rvalid;
    logic          cpu_err;

    logic          mem_rd;
    logic [AW-1:0] mem_addr;
    logic [15:0]   mem_rdata;
    logic [7:0]    mem_rcrc;
    logic          mem_wr;
    logic [15:0]   mem_wdata;

    logic          edac_en;
    logic          edac_read;
    logic [15:0]   edac_din;
    logic [7:0]    edac_crc;
    logic [15:0]   edac_dout;
    logic          edac_valid;

    modport master (
        input  cpu_req, cpu_addr, mem_rdata, mem_rcrc, edac_dout, edac_valid,
        output cpu_gnt, cpu_rdata, cpu_rvalid, cpu_err,
        output mem_rd, mem_addr, mem_wr, mem_wdata,
        output edac_en, edac_read, edac_din, edac_crc
    );

    modport slave (
        output cpu_req, cpu_addr, mem_rdata, mem_rcrc, edac_dout, edac_valid,
        input  cpu_gnt, cpu_rdata, cpu_rvalid, cpu_err,
        input  mem_rd, mem_addr, mem_wr, mem_wdata,
        input  edac_en, edac_read, edac_din, edac_crc
    );
endinterface

// File: rtl/edac_access_ctrl.sv
// Shares one memory read port and one EDAC checker between CPU reads and a background scrubber; EDAC_SCRUB_WB_EN adds scrub write-back.
// CPU grant->rvalid is 4 cycles plus EDAC wait; cpu_req is held until cpu_gnt, so requests arriving while busy wait in IDLE.
module edac_access_ctrl #(
    parameter int AW             = 10,
    parameter int SCRUB_INTERVAL = 1024,
    parameter int TIMEOUT        = 16
) (
    input  logic               CLK,
    input  logic               RST_N,
    edac_access_ctrl_if.master bus,
    output logic [7:0]         corr_cnt,
    output logic               busy
);
    localparam int TW = $clog2(SCRUB_INTERVAL);
    localparam int CW = $clog2(TIMEOUT);
    localparam logic [TW-1:0] TMR_RELOAD = TW'(SCRUB_INTERVAL - 1);
    localparam logic [CW-1:0] WAIT_LAST  = CW'(TIMEOUT - 1);

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_LOAD, S_CHECK, S_WB, S_RESP} state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [AW-1:0] scrub_addr_q, scrub_addr_d;
    logic          owner_scrub_q, owner_scrub_d;
    logic [15:0]   raw_q, raw_d;
    logic [7:0]    crc_q, crc_d;
    logic [15:0]   dout_q, dout_d;
    logic          err_q, err_d;
    logic [CW-1:0] wait_q, wait_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic          pend_q, pend_d;
    logic          urgent_q, urgent_d;
    logic [7:0]    corr_cnt_q, corr_cnt_d;

    logic          cpu_gnt, cpu_rvalid, cpu_err;
    logic [15:0]   cpu_rdata;
    logic          mem_rd, mem_wr;
    logic [AW-1:0] mem_addr;
    logic [15:0]   mem_wdata;
    logic          edac_en;
    logic          scrub_gnt, scrub_done;

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        scrub_addr_d  = scrub_addr_q;
        owner_scrub_d = owner_scrub_q;
        raw_d         = raw_q;
        crc_d         = crc_q;
        dout_d        = dout_q;
        err_d         = err_q;
        wait_d        = wait_q;
        tmr_d         = tmr_q;
        pend_d        = pend_q;
        urgent_d      = urgent_q;
        corr_cnt_d    = corr_cnt_q;
        cpu_gnt       = 1'b0;
        cpu_rvalid    = 1'b0;
        cpu_err       = 1'b0;
        cpu_rdata     = '0;
        mem_rd        = 1'b0;
        mem_wr        = 1'b0;
        mem_addr      = '0;
        mem_wdata     = '0;
        edac_en       = 1'b0;
        scrub_gnt     = 1'b0;
        scrub_done    = 1'b0;

        case (state_q)
            S_IDLE: begin
                // urgent implies pend, so an urgent scrub always lands in the second branch
                if (bus.cpu_req && !urgent_q) begin
                    cpu_gnt       = 1'b1;
                    addr_d        = bus.cpu_addr;
                    owner_scrub_d = 1'b0;
                    state_d       = S_FETCH;
                end else if (pend_q) begin
                    scrub_gnt     = 1'b1;
                    addr_d        = scrub_addr_q;
                    owner_scrub_d = 1'b1;
                    state_d       = S_FETCH;
                end
            end
            S_FETCH: begin
                mem_rd   = 1'b1;
                mem_addr = addr_q;
                state_d  = S_LOAD;
            end
            S_LOAD: begin
                raw_d   = bus.mem_rdata;
                crc_d   = bus.mem_rcrc;
                wait_d  = '0;
                err_d   = 1'b0;
                state_d = S_CHECK;
            end
            S_CHECK: begin
                edac_en = 1'b1;
                if (bus.edac_valid) begin
                    dout_d = bus.edac_dout;
                    if (!owner_scrub_q) begin
                        state_d = S_RESP;
                    end else if (bus.edac_dout != raw_q) begin
                        if (corr_cnt_q != 8'hFF) corr_cnt_d = corr_cnt_q + 8'd1;
`ifdef EDAC_SCRUB_WB_EN
                        state_d = S_WB;
`else
                        state_d    = S_IDLE;
                        scrub_done = 1'b1;
`endif
                    end else begin
                        state_d    = S_IDLE;
                        scrub_done = 1'b1;
                    end
                end else if (wait_q == WAIT_LAST) begin
                    err_d = 1'b1;
                    if (owner_scrub_q) begin
                        state_d    = S_IDLE;
                        scrub_done = 1'b1;
                    end else begin
                        state_d = S_RESP;
                    end
                end else begin
                    wait_d = wait_q + CW'(1);
                end
            end
`ifdef EDAC_SCRUB_WB_EN
            S_WB: begin
                mem_wr     = 1'b1;
                mem_addr   = scrub_addr_q;
                mem_wdata  = dout_q;
                scrub_done = 1'b1;
                state_d    = S_IDLE;
            end
`endif
            S_RESP: begin
                cpu_rvalid = 1'b1;
                cpu_err    = err_q;
                cpu_rdata  = err_q ? 16'h0000 : dout_q;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (scrub_done) scrub_addr_d = scrub_addr_q + AW'(1);

        // a grant clears the flags; an expiry in the same cycle raises a fresh request
        if (scrub_gnt) begin
            pend_d   = 1'b0;
            urgent_d = 1'b0;
        end
        if (tmr_q == '0) begin
            tmr_d  = TMR_RELOAD;
            pend_d = 1'b1;
            if (pend_q && !scrub_gnt) urgent_d = 1'b1;
        end else begin
            tmr_d = tmr_q - TW'(1);
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q       <= S_IDLE;
            addr_q        <= '0;
            scrub_addr_q  <= '0;
            owner_scrub_q <= 1'b0;
            raw_q         <= '0;
            crc_q         <= '0;
            dout_q        <= '0;
            err_q         <= 1'b0;
            wait_q        <= '0;
            tmr_q         <= TMR_RELOAD;
            pend_q        <= 1'b0;
            urgent_q      <= 1'b0;
            corr_cnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            scrub_addr_q  <= scrub_addr_d;
            owner_scrub_q <= owner_scrub_d;
            raw_q         <= raw_d;
            crc_q         <= crc_d;
            dout_q        <= dout_d;
            err_q         <= err_d;
            wait_q        <= wait_d;
            tmr_q         <= tmr_d;
            pend_q        <= pend_d;
            urgent_q      <= urgent_d;
            corr_cnt_q    <= corr_cnt_d;
        end
    end

    assign bus.cpu_gnt    = cpu_gnt;
    assign bus.cpu_rvalid = cpu_rvalid;
    assign bus.cpu_err    = cpu_err;
    assign bus.cpu_rdata  = cpu_rdata;
    assign bus.mem_rd     = mem_rd;
    assign bus.mem_addr   = mem_addr;
    assign bus.mem_wr     = mem_wr;
    assign bus.mem_wdata  = mem_wdata;
    assign bus.edac_en    = edac_en;
    assign bus.edac_read  = edac_en;
    assign bus.edac_din   = raw_q;
    assign bus.edac_crc   = crc_q;
    assign corr_cnt       = corr_cnt_q;
    assign busy           = (state_q != S_IDLE);
endmodule

// File: doc/edac_access_ctrl.md
# edac_access_ctrl

Sequencer and arbiter in front of the shared 4-bit EDAC checker (16-bit data, 8-bit check byte). It shares one EDAC instance and one synchronous memory read port between a CPU read requester and an internal background scrubber. It drives the EDAC `en`/`READ`/`DIN`/`CRC` inputs and waits for `valid`. For scrub accesses it writes corrected words back to memory.

## Interface
Parameters:
- AW, 10: memory address width.
- SCRUB_INTERVAL, 1024: cycles between scrub requests (≥4).
- TIMEOUT, 16: maximum cycles in CHECK waiting for edac_valid (≥2).

Ports:
- CLK  in  1  clock, rising edge.
- RST_N  in  1  asynchronous active-low reset.
- cpu_req  in  1  read request; held until cpu_gnt.
- cpu_addr  in  AW  request address; sampled when cpu_gnt=1.
- cpu_gnt  out  1  one-cycle grant pulse.
- cpu_rdata  out  16  corrected data; valid with cpu_rvalid.
- cpu_rvalid  out  1  one-cycle response pulse.
- cpu_err  out  1  asserted with cpu_rvalid on EDAC timeout.
- mem_rd  out  1  memory read strobe; data returns next cycle.
- mem_addr  out  AW  memory address.
- mem_rdata  in  16  raw data.
- mem_rcrc  in  8  stored check byte.
- mem_wr  out  1  one-cycle write-back strobe.
- mem_wdata  out  16  write-back data.
- edac_en, edac_read  out  1  EDAC enable / read-mode.
- edac_din  out  16, edac_crc  out  8  EDAC operands.
- edac_dout  in  16, edac_valid  in  1  EDAC result.
- corr_cnt  out  8  saturating count of scrub corrections.
- busy  out  1  high in any state except IDLE.

## Operation
- States: IDLE, FETCH, LOAD, CHECK, WB, RESP.
- IDLE → FETCH when cpu_req or scrub_pend is set.
  - CPU wins unless scrub_urgent is set.
  - On a CPU win, cpu_gnt pulses in the IDLE cycle and cpu_addr is latched.
  - On a scrub win, scrub_addr is latched.
  - The owner bit records which requester won.
- FETCH: mem_rd=1 for one cycle with mem_addr = latched address.
- LOAD: mem_rdata and mem_rcrc are captured at the end of the cycle into raw/crc registers.
- CHECK:
  - edac_en=1, edac_read=1, edac_din=raw, edac_crc=crc, held until edac_valid or timeout.
  - edac_dout is captured on edac_valid.
- Exit from CHECK:
  - CPU owner → RESP.
  - Scrub owner with edac_dout≠raw → corr_cnt+1 (saturates at 255), then → WB.
  - Scrub owner with edac_dout=raw → IDLE.
  - Scrub owner on timeout → IDLE with no count and no write.
- WB: mem_wr=1, mem_addr=scrub address, mem_wdata=captured dout, one cycle → IDLE.
- RESP:
  - cpu_rvalid=1 for one cycle.
  - cpu_rdata = captured dout, or 0 with cpu_err=1 on timeout.
  - → IDLE.
- Scrub timer:
  - Down-counter reloads SCRUB_INTERVAL-1 and runs in every state.
  - At 0 it sets scrub_pend.
  - If it reaches 0 again while scrub_pend is still set, it sets scrub_urgent.
  - Both flags clear when a scrub is granted.
- scrub_addr increments after each completed scrub (WB or IDLE exit), including after a timeout. It wraps from 2^AW-1 to 0.
- edac_en and edac_read are 0 in every state except CHECK. edac_din and edac_crc hold their last values.

## Timing
- Reset values:
  - All outputs 0; edac_din and edac_crc 0.
  - State IDLE, scrub_addr 0, timer SCRUB_INTERVAL-1, flags clear.
- RST_N low mid-operation: return to IDLE immediately (asynchronous). edac_en drops with no response and no write.
- CPU latency, zero-wait EDAC (edac_valid in the first CHECK cycle): cpu_gnt at cycle 0, cpu_rvalid at cycle 4. Each extra EDAC wait cycle adds one.
- Timeout: CHECK exits after TIMEOUT cycles without edac_valid. If edac_valid arrives in the final cycle, valid wins.
- Same-cycle cpu_req and scrub_pend: CPU wins unless scrub_urgent. A CPU request arriving while busy waits in IDLE.
- Back-to-back: a new grant is possible in the cycle after RESP or WB returns to IDLE.

## Configuration
- EDAC_SCRUB_WB_EN:
  - Defined: the WB state exists and corrected scrub words are written back.
  - Undefined: the scrub exits to IDLE after CHECK, mem_wr is tied 0, and corr_cnt still counts corrections.

## Test plan
- CPU read, addr 0x005, memory returns 0x0B29/0x09, EDAC returns 0x0B29 in 1 cycle → cpu_gnt at cycle 0, cpu_rvalid at cycle 4, cpu_rdata=0x0B29, cpu_err=0, mem_wr never asserted.
- Scrub with SCRUB_INTERVAL=8, raw 0x0B29, EDAC returns 0x0B28 → mem_wr pulse, addr 0, mem_wdata=0x0B28, corr_cnt=1, next scrub at addr 1.
  - Same stimulus with the macro undefined → corr_cnt=1, no mem_wr.
- edac_valid never asserted, TIMEOUT=16 → cpu_rvalid=1 with cpu_err=1 and cpu_rdata=0 exactly 16 CHECK cycles after entry.
- cpu_req held continuously with SCRUB_INTERVAL=8 → CPU wins the first contention; after the second timer expiry (urgent) the scrub is granted ahead of the CPU.
- Reset pulsed during CHECK → edac_en=0, busy=0, corr_cnt=0 immediately; no cpu_rvalid afterward.
- scrub_addr at 2^AW-1 (AW=2, address 3) → next scrub address 0.
